hazard_tracker: RTL and testbench

//  Pipeline hazard unit for the 5-stage MIPS core. Consumes the D-stage decoder's Tuse/Tnew/A3 info
//  and keeps shadow E/M/W copies of (A3, write-enable, Tnew), counting Tnew down per stage.

---
 rtl/hazard_tracker.sv | 140 ++++++++++++++
 tb/tb_hazard_tracker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// ============================================================================
//  hazard_tracker : stall and bypass-select generation for the 5-stage MIPS core
//  Optional stall counter output enabled by defining HAZARD_STALL_CNT_EN.
//  Rev 1.0
// ============================================================================
`default_nettype none

module hazard_tracker #(
  parameter int REG_W  = 5,
  parameter int TNEW_W = 3
`ifdef HAZARD_STALL_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  D_rs,
  input  logic [REG_W-1:0]  D_rt,
  input  logic              Tuse_rs0,
  input  logic              Tuse_rs1,
  input  logic              Tuse_rt0,
  input  logic              Tuse_rt1,
  input  logic              Tuse_rt2,
  input  logic [REG_W-1:0]  D_A3,
  input  logic              D_RegWrite,
  input  logic [TNEW_W-1:0] D_Tnew,
  output logic              stall,
  output logic [1:0]        fwd_D_rs,
  output logic [1:0]        fwd_D_rt,
  output logic [1:0]        fwd_E_rs,
  output logic [1:0]        fwd_E_rt,
  output logic              fwd_M_rt
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  // Tuse reaches 7 ("unused"), so comparisons need at least 3 bits.
  localparam int CMP_W = (TNEW_W > 3) ? TNEW_W : 3;

  logic [REG_W-1:0]  e_a3_q, e_a3_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d;
  logic              e_we_q, e_we_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
  logic [REG_W-1:0]  m_a3_q, m_a3_d, m_rt_q, m_rt_d;
  logic              m_we_q, m_we_d;
  logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
  logic [REG_W-1:0]  w_a3_q, w_a3_d;
  logic              w_we_q, w_we_d;

  logic              e_valid, m_valid, w_valid;
  logic [CMP_W-1:0]  tuse_rs, tuse_rt, e_tnew_x, m_tnew_x;

  always_comb begin
    e_valid  = e_we_q && (e_a3_q != '0);
    m_valid  = m_we_q && (m_a3_q != '0);
    w_valid  = w_we_q && (w_a3_q != '0);
    e_tnew_x = CMP_W'(e_tnew_q);
    m_tnew_x = CMP_W'(m_tnew_q);
    tuse_rs  = Tuse_rs0 ? CMP_W'(0) : Tuse_rs1 ? CMP_W'(1) : CMP_W'(7);
    tuse_rt  = Tuse_rt0 ? CMP_W'(0) : Tuse_rt1 ? CMP_W'(1) :
               Tuse_rt2 ? CMP_W'(2) : CMP_W'(7);
  end

  always_comb begin
    stall = (e_valid && (e_a3_q == D_rs) && (e_tnew_x > tuse_rs)) ||
            (m_valid && (m_a3_q == D_rs) && (m_tnew_x > tuse_rs)) ||
            (e_valid && (e_a3_q == D_rt) && (e_tnew_x > tuse_rt)) ||
            (m_valid && (m_a3_q == D_rt) && (m_tnew_x > tuse_rt));
  end

  // Only stages whose result already exists may be selected; newest first.
  always_comb begin
    fwd_D_rs = 2'd0;
    if (e_valid && (e_a3_q == D_rs) && (e_tnew_q == '0))      fwd_D_rs = 2'd3;
    else if (m_valid && (m_a3_q == D_rs) && (m_tnew_q == '0)) fwd_D_rs = 2'd2;
    else if (w_valid && (w_a3_q == D_rs))                     fwd_D_rs = 2'd1;

    fwd_D_rt = 2'd0;
    if (e_valid && (e_a3_q == D_rt) && (e_tnew_q == '0))      fwd_D_rt = 2'd3;
    else if (m_valid && (m_a3_q == D_rt) && (m_tnew_q == '0)) fwd_D_rt = 2'd2;
    else if (w_valid && (w_a3_q == D_rt))                     fwd_D_rt = 2'd1;

    fwd_E_rs = 2'd0;
    if (m_valid && (m_a3_q == e_rs_q) && (m_tnew_q == '0))    fwd_E_rs = 2'd2;
    else if (w_valid && (w_a3_q == e_rs_q))                   fwd_E_rs = 2'd1;

    fwd_E_rt = 2'd0;
    if (m_valid && (m_a3_q == e_rt_q) && (m_tnew_q == '0))    fwd_E_rt = 2'd2;
    else if (w_valid && (w_a3_q == e_rt_q))                   fwd_E_rt = 2'd1;

    fwd_M_rt = w_valid && (w_a3_q == m_rt_q);
  end

  always_comb begin
    e_a3_d   = stall ? '0 : D_A3;
    e_we_d   = stall ? 1'b0 : D_RegWrite;
    e_tnew_d = stall ? '0 : D_Tnew;
    e_rs_d   = stall ? '0 : D_rs;
    e_rt_d   = stall ? '0 : D_rt;
    m_a3_d   = e_a3_q;
    m_we_d   = e_we_q;
    m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - TNEW_W'(1);
    m_rt_d   = e_rt_q;
    w_a3_d   = m_a3_q;
    w_we_d   = m_we_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3_q <= '0; e_we_q <= 1'b0; e_tnew_q <= '0; e_rs_q <= '0; e_rt_q <= '0;
      m_a3_q <= '0; m_we_q <= 1'b0; m_tnew_q <= '0; m_rt_q <= '0;
      w_a3_q <= '0; w_we_q <= 1'b0;
    end else begin
      e_a3_q <= e_a3_d; e_we_q <= e_we_d; e_tnew_q <= e_tnew_d;
      e_rs_q <= e_rs_d; e_rt_q <= e_rt_d;
      m_a3_q <= m_a3_d; m_we_q <= m_we_d; m_tnew_q <= m_tnew_d; m_rt_q <= m_rt_d;
      w_a3_q <= w_a3_d; w_we_q <= w_we_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_tracker.sv
// ============================================================================
//  tb_hazard_tracker : directed pipeline scenarios plus random traffic,
//  checked against a stage-array reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic       t_rs0, t_rs1, t_rt0, t_rt1, t_rt2, d_we;
  logic [2:0] d_tnew;
  logic       stall, fwd_M_rt;
  logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] m_cnt;
`endif

  always #5 clk = ~clk;

  hazard_tracker dut (
    .clk(clk), .reset(reset), .D_rs(d_rs), .D_rt(d_rt),
    .Tuse_rs0(t_rs0), .Tuse_rs1(t_rs1), .Tuse_rt0(t_rt0), .Tuse_rt1(t_rt1), .Tuse_rt2(t_rt2),
    .D_A3(d_a3), .D_RegWrite(d_we), .D_Tnew(d_tnew),
    .stall(stall), .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
    .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Reference: pipe[0]=E, pipe[1]=M, pipe[2]=W; tnew = cycles until result exists.
  typedef struct {int a3; bit we; int tnew; int rs; int rt;} slot_t;
  slot_t pipe[3];

  int n_vec = 0;
  int n_err = 0;
  int last_d_rs, last_d_rt, last_e_rt;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit valid(int s);
    return pipe[s].we && pipe[s].a3 != 0;
  endfunction

  function automatic int use_rs();
    return t_rs0 ? 0 : t_rs1 ? 1 : 7;
  endfunction

  function automatic int use_rt();
    return t_rt0 ? 0 : t_rt1 ? 1 : t_rt2 ? 2 : 7;
  endfunction

  function automatic bit m_stall();
    bit s = 0;
    for (int i = 0; i < 2; i++) begin
      if (valid(i) && pipe[i].a3 == int'(d_rs) && pipe[i].tnew > use_rs()) s = 1;
      if (valid(i) && pipe[i].a3 == int'(d_rt) && pipe[i].tnew > use_rt()) s = 1;
    end
    return s;
  endfunction

  // First ready producer among stages lo..2 holding reg r; code is 3 - stage.
  function automatic int m_fwd(int r, int lo);
    for (int i = lo; i < 3; i++)
      if (valid(i) && pipe[i].a3 == r && (i == 2 || pipe[i].tnew == 0)) return 3 - i;
    return 0;
  endfunction

  task automatic set_d(input int a3, input bit we, input int tnew, input int rs, input int rt,
                       input logic [4:0] fl);
    d_a3 = 5'(a3); d_we = we; d_tnew = 3'(tnew); d_rs = 5'(rs); d_rt = 5'(rt);
    {t_rs0, t_rs1, t_rt0, t_rt1, t_rt2} = fl;
  endtask

  task automatic step(input bit rst_v, output bit st);
    bit es;
    reset = rst_v;
    #1;
    es = m_stall();
    check_eq("stall", int'(stall), int'(es));
    check_eq("fwd_D_rs", int'(fwd_D_rs), m_fwd(int'(d_rs), 0));
    check_eq("fwd_D_rt", int'(fwd_D_rt), m_fwd(int'(d_rt), 0));
    check_eq("fwd_E_rs", int'(fwd_E_rs), m_fwd(pipe[0].rs, 1));
    check_eq("fwd_E_rt", int'(fwd_E_rt), m_fwd(pipe[0].rt, 1));
    check_eq("fwd_M_rt", int'(fwd_M_rt), int'(valid(2) && pipe[2].a3 == pipe[1].rt));
`ifdef HAZARD_STALL_CNT_EN
    check_eq("stall_cnt", int'(stall_cnt), int'(m_cnt));
`endif
    st = stall;
    last_d_rs = int'(fwd_D_rs); last_d_rt = int'(fwd_D_rt); last_e_rt = int'(fwd_E_rt);
    @(posedge clk);
    if (rst_v) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
`ifdef HAZARD_STALL_CNT_EN
      m_cnt = 0;
`endif
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[1].tnew = (pipe[0].tnew > 0) ? pipe[0].tnew - 1 : 0;
      if (es) pipe[0] = '{0, 0, 0, 0, 0};
      else    pipe[0] = '{int'(d_a3), d_we, int'(d_tnew), int'(d_rs), int'(d_rt)};
`ifdef HAZARD_STALL_CNT_EN
      m_cnt = m_cnt + 32'(es);
`endif
    end
    #1;
  endtask

  // Hold an instruction in D until it leaves; returns observed stall cycles.
  task automatic issue(input int a3, input bit we, input int tnew, input int rs, input int rt,
                       input logic [4:0] fl, output int stalls);
    bit st;
    int k;
    stalls = 0;
    set_d(a3, we, tnew, rs, rt, fl);
    for (k = 0; k < 8; k++) begin
      step(1'b0, st);
      if (!st) break;
      stalls++;
    end
    if (k == 8) check_eq("issue_timeout", k, 0);
  endtask

  task automatic flush();
    bit st;
    set_d(0, 0, 0, 0, 0, 5'b0);
    repeat (3) step(1'b0, st);
  endtask

  initial begin
    bit st;
    int ns;
    reset = 1'b1;
    set_d(0, 0, 0, 0, 0, 5'b0);
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
`ifdef HAZARD_STALL_CNT_EN
    m_cnt = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    set_d(3, 1, 2, 3, 3, 5'b11111);
    #1;
    check_eq("rst_stall", int'(stall), 0);
    check_eq("rst_fwd_D_rs", int'(fwd_D_rs), 0);
    check_eq("rst_fwd_E_rt", int'(fwd_E_rt), 0);
    check_eq("rst_fwd_M_rt", int'(fwd_M_rt), 0);
    #1;
    step(1'b0, st);
    flush();

    // lw $1 ; addu $3,$1,$2
    issue(1, 1, 2, 2, 0, 5'b01000, ns);
    issue(3, 1, 1, 1, 2, 5'b01010, ns);
    check_eq("lw_addu_stalls", ns, 1);
    set_d(0, 0, 0, 0, 0, 5'b0);
    #1;
    check_eq("lw_addu_fwdE", int'(fwd_E_rs), 1);
    #1;
    flush();

    // lw $1 ; beq $1,$2
    issue(1, 1, 2, 2, 0, 5'b01000, ns);
    issue(0, 0, 0, 1, 2, 5'b10100, ns);
    check_eq("lw_beq_stalls", ns, 2);
    check_eq("lw_beq_fwdD", last_d_rs, 1);
    flush();

    // ori $5 ; beq $5,$5
    issue(5, 1, 1, 0, 5, 5'b01000, ns);
    issue(0, 0, 0, 5, 5, 5'b10100, ns);
    check_eq("ori_beq_stalls", ns, 1);
    check_eq("ori_beq_fwd_rs", last_d_rs, 2);
    check_eq("ori_beq_fwd_rt", last_d_rt, 2);
    flush();

    // jal ; jr $31
    issue(31, 1, 0, 0, 0, 5'b00000, ns);
    issue(0, 0, 0, 31, 0, 5'b10000, ns);
    check_eq("jal_jr_stalls", ns, 0);
    check_eq("jal_jr_fwd", last_d_rs, 3);
    flush();

    // ori $0 ; beq $0,$0
    issue(0, 1, 1, 0, 0, 5'b01000, ns);
    issue(0, 0, 0, 0, 0, 5'b10100, ns);
    check_eq("zero_stalls", ns, 0);
    check_eq("zero_fwd_rs", last_d_rs, 0);
    check_eq("zero_fwd_rt", last_d_rt, 0);
    flush();

    // addu $4 ; sw $4,0($6)
    issue(4, 1, 1, 1, 2, 5'b01010, ns);
    issue(0, 0, 0, 6, 4, 5'b01001, ns);
    check_eq("addu_sw_stalls", ns, 0);
    set_d(0, 0, 0, 0, 0, 5'b0);
    step(1'b0, st);
    check_eq("addu_sw_fwdE", last_e_rt, 2);
    flush();

    // Reset while a beq is stalled behind lw
    issue(1, 1, 2, 0, 0, 5'b01000, ns);
    set_d(0, 0, 0, 1, 1, 5'b10100);
    step(1'b1, st);
    check_eq("midrst_was_stalled", int'(st), 1);
    reset = 1'b0;
    #1;
    check_eq("midrst_stall", int'(stall), 0);
    check_eq("midrst_fwd", int'(fwd_D_rs), 0);
    #1;
    flush();

    for (int n = 0; n < 400; n++) begin
      set_d(int'($urandom_range(0, 3)), 1'($urandom),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 5'($urandom));
      step(($urandom_range(0, 49) == 0), st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
